// File: rtl/decode_unit_pkg.sv
// Shared decode-stage definitions: RV32I opcodes, immediate formats and ID FSM states.
package decode_unit_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_DECODE, ST_WAIT_RS1, ST_HOLD} id_state_e;

  function automatic logic is_rv32i_opc(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_unit_imm_gen.sv
// Immediate generator: classifies the instruction format and builds the sign-extended immediate.
module imm_gen_sbm
  import decode_unit_pkg::*;
(
  input  logic [31:0] inst,
  output imm_type_e   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type = IMM_I;
      OPC_STORE:                      imm_type = IMM_S;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_JAL:                        imm_type = IMM_J;
      default:                        imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    case (imm_type)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// ID stage: holds one fetched instruction, decodes it for EX and issues JAL/JALR/branch redirects.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              misspredict_i,
  output logic              ready_o,
  output logic              jmp_o,
  output logic              branch_o,
  output logic [ADDR_W-1:0] jmp_target_o,
  output logic              inst31_o,
  input  logic [31:0]       rs1_data_i,
  input  logic              rs1_ready_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);

  id_state_e         state_q, state_d, st;
  logic              vld_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] pc_q;
  imm_type_e         imm_type;
  logic [31:0]       imm;
  logic [ADDR_W-1:0] imm_a, tgt_sum;
  logic              is_jal, is_jalr, is_br, load, handshake;

  imm_gen_sbm u_imm_gen (
    .inst     (inst_q),
    .imm_type (imm_type),
    .imm      (imm)
  );

  assign is_jal  = (imm_type == IMM_J);
  assign is_br   = (imm_type == IMM_B);
  assign is_jalr = (inst_q[6:0] == OPC_JALR);

  // Effective state: a freshly loaded JALR whose rs1 is not ready behaves as a wait,
  // and a waiting JALR decodes in the same cycle its rs1 becomes ready.
  always_comb begin
    st = state_q;
    if (state_q == ST_DECODE && is_jalr && !rs1_ready_i) begin
      st = ST_WAIT_RS1;
    end else if (state_q == ST_WAIT_RS1 && rs1_ready_i) begin
      st = ST_DECODE;
    end
  end

  assign valid_o   = vld_q && (st != ST_WAIT_RS1);
  assign handshake = valid_o && ready_i;
  assign ready_o   = !vld_q || handshake;
  assign load      = valid_i && ready_o && !misspredict_i;

  always_comb begin
    state_d = st;
    if (misspredict_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY:    state_d = load ? ST_DECODE : ST_EMPTY;
        ST_WAIT_RS1: state_d = ST_WAIT_RS1;
        default:     state_d = handshake ? (load ? ST_DECODE : ST_EMPTY) : ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (misspredict_i) begin
        vld_q <= 1'b0;
      end else if (load) begin
        vld_q <= 1'b1;
      end else if (handshake) begin
        vld_q <= 1'b0;
      end
      if (load) begin
        inst_q <= inst_i;
        pc_q   <= pc_i;
      end
    end
  end

  assign imm_a   = ADDR_W'($signed(imm));
  assign tgt_sum = is_jalr ? (ADDR_W'(rs1_data_i) + imm_a) : (pc_q + imm_a);

  assign jmp_o        = (st == ST_DECODE) && !misspredict_i && (is_jal || is_jalr);
  assign branch_o     = (st == ST_DECODE) && !misspredict_i && is_br;
  assign jmp_target_o = {tgt_sum[ADDR_W-1:1], tgt_sum[0] & !is_jalr};

  assign inst31_o  = inst_q[31];
  assign pc_o      = pc_q;
  assign inst_o    = inst_q;
  assign rs1_o     = inst_q[19:15];
  assign rs2_o     = inst_q[24:20];
  assign rd_o      = inst_q[11:7];
  assign funct3_o  = inst_q[14:12];
  assign funct7_o  = inst_q[31:25];
  assign imm_o     = imm;
  assign illegal_o = vld_q && !is_rv32i_opc(inst_q[6:0]);

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: per-scenario tasks plus an EX-side monitor that pops expectations.
module tb_decode_unit;

  logic        clk, rst;
  logic        valid_i, misspredict_i, rs1_ready_i, ready_i;
  logic [31:0] inst_i, pc_i, rs1_data_i;
  logic        ready_o, jmp_o, branch_o, inst31_o, valid_o, illegal_o;
  logic [31:0] jmp_target_o, pc_o, inst_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  decode_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .inst_i       (inst_i),
    .pc_i         (pc_i),
    .misspredict_i(misspredict_i),
    .ready_o      (ready_o),
    .jmp_o        (jmp_o),
    .branch_o     (branch_o),
    .jmp_target_o (jmp_target_o),
    .inst31_o     (inst31_o),
    .rs1_data_i   (rs1_data_i),
    .rs1_ready_i  (rs1_ready_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .rs1_o        (rs1_o),
    .rs2_o        (rs2_o),
    .rd_o         (rd_o),
    .funct3_o     (funct3_o),
    .funct7_o     (funct7_o),
    .imm_o        (imm_o),
    .illegal_o    (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // EX side: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc_o=%h inst_o=%h, required no output", pc_o, inst_o);
      end else begin
        mon_e = sb.pop_front();
        if ({pc_o, inst_o, imm_o, rd_o, rs1_o, rs2_o, funct3_o, illegal_o} !==
            {mon_e.pc, mon_e.inst, mon_e.imm, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3, mon_e.ill}) begin
          bad++;
          $display("FAIL sb_fields: got pc=%h inst=%h imm=%h rd=%0d rs1=%0d rs2=%0d f3=%0d ill=%b, required pc=%h inst=%h imm=%h rd=%0d rs1=%0d rs2=%0d f3=%0d ill=%b",
                   pc_o, inst_o, imm_o, rd_o, rs1_o, rs2_o, funct3_o, illegal_o,
                   mon_e.pc, mon_e.inst, mon_e.imm, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3, mon_e.ill);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic ill);
    exp_t e;
    e.pc = pc; e.inst = inst; e.imm = imm; e.rd = rd;
    e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    @(posedge clk); #1;
    valid_i = 1'b1;
    inst_i  = inst;
    pc_i    = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({valid_o, jmp_o, branch_o, ready_o, illegal_o} !== 5'b00010) begin
      bad++;
      $display("FAIL reset_ctrl: got valid/jmp/br/ready/ill=%b, required 00010",
               {valid_o, jmp_o, branch_o, ready_o, illegal_o});
    end
    total++;
    if ({pc_o, inst_o} !== 64'h0) begin
      bad++;
      $display("FAIL reset_fields: got pc_o=%h inst_o=%h, required 0/0", pc_o, inst_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    ready_i = 1'b1;
    present(32'h002081B3, 32'h100);
    push_exp(32'h100, 32'h002081B3, 32'h0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_o, ready_o, jmp_o, branch_o, rd_o, rs1_o, rs2_o} !== {4'b1100, 5'd3, 5'd1, 5'd2}) begin
      bad++;
      $display("FAIL add_decode: got valid=%b ready=%b jmp=%b br=%b rd=%0d rs1=%0d rs2=%0d, required 1 1 0 0 3 1 2",
               valid_o, ready_o, jmp_o, branch_o, rd_o, rs1_o, rs2_o);
    end
    idle(1);
  endtask

  task automatic test_jal_stall();
    ready_i = 1'b0;
    present(32'h020000EF, 32'h40);
    push_exp(32'h40, 32'h020000EF, 32'h20, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({jmp_o, valid_o, jmp_target_o} !== {2'b11, 32'h60}) begin
      bad++;
      $display("FAIL jal_pulse: got jmp=%b valid=%b target=%h, required 1 1 00000060",
               jmp_o, valid_o, jmp_target_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({jmp_o, valid_o, ready_o} !== 3'b010) begin
        bad++;
        $display("FAIL jal_no_repeat: cycle %0d got jmp=%b valid=%b ready=%b, required 0 1 0",
                 i, jmp_o, valid_o, ready_o);
      end
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (jmp_o !== 1'b0) begin
      bad++;
      $display("FAIL jal_release: got jmp=%b, required 0", jmp_o);
    end
    idle(1);
  endtask

  task automatic test_jalr_wait();
    ready_i     = 1'b1;
    rs1_ready_i = 1'b0;
    rs1_data_i  = 32'h1001;
    present(32'h00828067, 32'h300);
    push_exp(32'h300, 32'h00828067, 32'h8, 5'd0, 5'd5, 5'd8, 3'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({valid_o, ready_o, jmp_o} !== 3'b000) begin
        bad++;
        $display("FAIL jalr_wait: cycle %0d got valid=%b ready=%b jmp=%b, required 0 0 0",
                 i, valid_o, ready_o, jmp_o);
      end
      @(posedge clk); #1;
    end
    rs1_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if ({jmp_o, valid_o, jmp_target_o} !== {2'b11, 32'h1008}) begin
      bad++;
      $display("FAIL jalr_target: got jmp=%b valid=%b target=%h, required 1 1 00001008",
               jmp_o, valid_o, jmp_target_o);
    end
    idle(1);
  endtask

  task automatic test_branch_neg();
    ready_i = 1'b1;
    present(32'hFE2088E3, 32'h200);
    push_exp(32'h200, 32'hFE2088E3, 32'hFFFFFFF0, 5'd17, 5'd1, 5'd2, 3'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({branch_o, jmp_o, inst31_o, jmp_target_o, imm_o} !== {3'b101, 32'h1F0, 32'hFFFFFFF0}) begin
      bad++;
      $display("FAIL branch_neg: got br=%b jmp=%b i31=%b target=%h imm=%h, required 1 0 1 000001f0 fffffff0",
               branch_o, jmp_o, inst31_o, jmp_target_o, imm_o);
    end
    idle(1);
  endtask

  task automatic test_misspredict();
    ready_i = 1'b1;
    present(32'h020000EF, 32'h600);
    push_exp(32'h600, 32'h020000EF, 32'h20, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0);
    @(posedge clk); #1;
    misspredict_i = 1'b1;
    inst_i        = 32'h002081B3;
    pc_i          = 32'h700;
    @(negedge clk);
    total++;
    if (jmp_o !== 1'b0) begin
      bad++;
      $display("FAIL mp_jmp_forced: got jmp=%b, required 0", jmp_o);
    end
    @(posedge clk); #1;
    misspredict_i = 1'b0;
    valid_i       = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_o, ready_o, jmp_o} !== 3'b010) begin
      bad++;
      $display("FAIL mp_flush: got valid=%b ready=%b jmp=%b, required 0 1 0", valid_o, ready_o, jmp_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mp_not_loaded: got valid=%b, required 0", valid_o);
    end
  endtask

  task automatic test_illegal();
    ready_i = 1'b1;
    present(32'h0000007F, 32'h800);
    push_exp(32'h800, 32'h0000007F, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({illegal_o, valid_o} !== 2'b11) begin
      bad++;
      $display("FAIL illegal: got ill=%b valid=%b, required 1 1", illegal_o, valid_o);
    end
    idle(1);
  endtask

  task automatic test_wrap();
    ready_i = 1'b1;
    present(32'h00000863, 32'hFFFFFFF8);
    push_exp(32'hFFFFFFF8, 32'h00000863, 32'h10, 5'd16, 5'd0, 5'd0, 3'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    total++;
    if ({branch_o, jmp_target_o} !== {1'b1, 32'h8}) begin
      bad++;
      $display("FAIL branch_wrap: got br=%b target=%h, required 1 00000008", branch_o, jmp_target_o);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ins = {7'b0, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
      present(ins, 32'h1000 + 32'(i * 4));
      push_exp(32'h1000 + 32'(i * 4), ins, 32'h0, ins[11:7], ins[19:15], ins[24:20], ins[14:12], 1'b0);
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready: beat %0d got ready=%b, required 1", i, ready_o);
      end
    end
    idle(2);
  endtask

  task automatic test_stall();
    logic [31:0] ins;
    int sent = 0;
    int cyc = 0;
    bit acc = 0;
    while ((sent < 6 || acc) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        valid_i = 1'b0;
        acc = 0;
      end
      ready_i = 1'($urandom_range(0, 1));
      if (!valid_i && sent < 6) begin
        ins = {7'b0, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
        valid_i = 1'b1;
        inst_i  = ins;
        pc_i    = 32'h2000 + 32'(sent * 4);
      end
      @(negedge clk);
      if (valid_i && ready_o) begin
        push_exp(pc_i, inst_i, 32'h0, inst_i[11:7], inst_i[19:15], inst_i[24:20], inst_i[14:12], 1'b0);
        sent++;
        acc = 1;
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    idle(3);
    total++;
    if (sent != 6) begin
      bad++;
      $display("FAIL stall_progress: got %0d accepted, required 6", sent);
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0; inst_i = '0; pc_i = '0;
    misspredict_i = 1'b0; rs1_ready_i = 1'b1; rs1_data_i = '0; ready_i = 1'b0;
    test_reset();
    test_add();
    test_jal_stall();
    test_jalr_wait();
    test_branch_neg();
    test_misspredict();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_stall();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
# decode_unit

In-order ID stage directly downstream of the fetch unit. It registers one instruction from fetch and decodes it into register indices, function fields and a sign-extended immediate for the execute stage. It computes JAL/JALR/branch targets and drives the redirect controls back to fetch. Wrong-path contents are dropped on a misprediction.

## Interface
Parameters:
- ADDR_W, 32, PC/target width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  fetch presents inst_i/pc_i.
- inst_i  in  32  instruction from fetch.
- pc_i  in  ADDR_W  PC of inst_i.
- misspredict_i  in  1  branch resolved against prediction; ID contents are wrong-path.
- ready_o  out  1  ID accepts inst_i this cycle (to fetch ready_i).
- jmp_o  out  1  one-cycle pulse: held JAL/JALR redirects fetch.
- branch_o  out  1  one-cycle pulse: held conditional branch decoded.
- jmp_target_o  out  ADDR_W  redirect/branch target.
- inst31_o  out  1  held instruction bit 31 (predictor sign).
- rs1_data_i  in  32  register-file read of rs1_o.
- rs1_ready_i  in  1  no pending write to rs1_o.
- valid_o  out  1  decoded instruction valid to EX.
- ready_i  in  1  EX accepts this cycle.
- pc_o, inst_o  out  ADDR_W/32  held PC and raw instruction.
- rs1_o, rs2_o, rd_o  out  5 each.
- funct3_o  out  3; funct7_o  out  7; imm_o  out  32.
- illegal_o  out  1  opcode not in the RV32I base set.

## Operation
- Holds one ID register: {vld, inst, pc}.
- Load condition: valid_i && ready_o && !misspredict_i.
- ready_o = !vld || (valid_o && ready_i), combinational.
- FSM states:
  - ST_EMPTY: vld = 0.
  - ST_DECODE: first cycle of a newly loaded instruction.
  - ST_WAIT_RS1: JALR waiting for rs1_ready_i.
  - ST_HOLD: redirect already issued, or non-control instruction waiting for ready_i.
- Transitions:
  - Load → ST_DECODE, except when the loaded opcode is JALR and rs1_ready_i is low in the next cycle → ST_WAIT_RS1.
  - ST_DECODE / ST_HOLD with handshake: load in the same cycle → ST_DECODE; otherwise → ST_EMPTY.
  - ST_DECODE without handshake → ST_HOLD.
  - ST_WAIT_RS1 → ST_DECODE when rs1_ready_i = 1.
- Redirect pulses occur only in ST_DECODE with !misspredict_i:
  - JAL: jmp_o = 1, target = pc + J-imm.
  - JALR: jmp_o = 1, target = (rs1_data_i + I-imm) & ~1.
  - BRANCH: branch_o = 1, target = pc + B-imm.
- valid_o = vld && state ≠ ST_WAIT_RS1; in ST_WAIT_RS1, valid_o = 0 and ready_o = 0.
- Immediates are sign-extended from inst[31]:
  - I: OP_IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Other opcodes: imm_o = 0.
- Target arithmetic is mod 2^ADDR_W; wrap-around is permitted.
- misspredict_i has priority over all other events: vld ← 0 next edge, state → ST_EMPTY, jmp_o/branch_o forced 0, incoming valid_i ignored.
- illegal_o is passed along with valid_o; no trap is raised here.

## Timing
- Reset values: vld = 0, state = ST_EMPTY, valid_o = 0, jmp_o = 0, branch_o = 0, ready_o = 1. Registered fields reset to 0.
- Latency: accepted at edge N → valid_o, jmp_o, branch_o in cycle N+1 (non-JALR, or JALR with rs1 ready).
- Decode fields, targets and pulses are combinational from the ID register and rs1_data_i.
- Throughput: 1 instruction/cycle when ready_i stays high.
- A redirect pulse never repeats for the same instruction, including across EX stalls.
- Reset asserted mid-operation: flush immediately, asynchronously.

## Structure
- Package typedefs holds:
  - the existing OPC_* opcode constants;
  - new enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - new enum id_state_e.
- Sub-module imm_gen_sbm (combinational): inst → {imm_type, imm}. Used for both imm_o and target computation.

## Test plan
- ADD x3,x1,x2 (0x002081B3) at pc 0x100, ready_i = 1 → next cycle valid_o = 1, rd_o = 3, rs1_o = 1, rs2_o = 2, ready_o = 1, jmp_o = 0.
- JAL x1,+0x20 at pc 0x40 → jmp_o pulses once with jmp_target_o = 0x60. With ready_i held 0 for 3 cycles, jmp_o stays 0 after the first cycle.
- JALR x0,8(x5), rs1_ready_i = 0 for 2 cycles, rs1_data_i = 0x1001 → valid_o = 0 and ready_o = 0 for 2 cycles; then jmp_o = 1, target 0x1008.
- BEQ with inst[31] = 1 at pc 0x200, offset −16 → branch_o = 1, jmp_target_o = 0x1F0, inst31_o = 1, imm_o = 0xFFFFFFF0.
- ID holding an instruction, with misspredict_i and valid_i both high in the same cycle → next cycle valid_o = 0, state ST_EMPTY, incoming instruction not loaded.
- Opcode 0x7F → illegal_o = 1 with valid_o = 1. Branch at pc 0xFFFFFFF8 with offset +16 → target wraps to 0x00000008.
